blake2_feeder: RTL and testbench
================================

BLAKE2_FEEDER -- requirements
Module: blake2_feeder

Interface
REQ-001 SHALL have parameter BLOCK_BYTES, default 64, meaning bytes per compression block delivered to the core.
REQ-002 SHALL have parameter IDX_W, default 6, meaning width of core byte index, equal to log2(BLOCK_BYTES).
REQ-003 SHALL have parameter LL_W, default 128, meaning width of message byte-length counter driven to core.
REQ-004 SHALL have parameter NN_W, default 7, meaning width of digest-length field.
REQ-005 SHALL have ports: clk in 1 clock; nreset in 1 reset, asynchronous, active-low; one clock domain only.
REQ-006 SHALL have ports: s_valid_i in 1 byte valid; s_data_i in 8 message byte; s_last_i in 1 final message byte; s_ready_o out 1 byte accepted when high with s_valid_i.
REQ-007 SHALL have ports: cfg_nn_i in NN_W digest bytes requested; cfg_kk_i in NN_W key length.
REQ-008 SHALL have ports: core_ready_i in 1 core ready; core_data_v_o out 1; core_data_idx_o out IDX_W; core_data_o out 8; core_block_first_o out 1; core_block_last_o out 1; core_ll_o out LL_W; core_nn_o out NN_W; core_kk_o out NN_W.
REQ-009 SHALL have ports: core_h_v_i in 1 digest byte valid; core_h_i in 8 digest byte; res_v_o out 1; res_data_o out 8; res_last_o out 1; busy_o out 1.

Function
REQ-010 SHALL implement FSM with states IDLE, FILL, PAD, GAP, RESULT.
REQ-011 In IDLE and FILL, s_ready_o SHALL equal core_ready_i; in PAD, GAP and RESULT, s_ready_o SHALL be 0.
REQ-012 Every accepted byte at cycle N SHALL appear at cycle N+1 on core_data_o, with core_data_v_o=1 and core_data_idx_o equal to the block byte counter.
REQ-013 The block byte counter SHALL start at 0 and wrap from BLOCK_BYTES-1 to 0.
REQ-014 Transitions:
- IDLE->FILL on first accepted byte; cfg_nn_i and cfg_kk_i SHALL be latched on that byte into core_nn_o and core_kk_o, held until return to IDLE.
- FILL->GAP on accepted byte at idx BLOCK_BYTES-1.
- FILL->PAD on accepted s_last_i byte with idx < BLOCK_BYTES-1.
- PAD SHALL emit 0x00 bytes, one per cycle, at consecutive idx up to BLOCK_BYTES-1, ignoring core_ready_i; then go to GAP.
- GAP->FILL when core_ready_i=1 after at least 2 cycles in GAP, for non-last blocks.
- GAP->RESULT directly, for the last block.
- RESULT->IDLE on the cycle res_last_o is driven.
REQ-015 core_block_first_o SHALL be 1 for every byte of the first block of a message, else 0.
REQ-016 core_block_last_o SHALL be 1 for every pad byte, and for the idx BLOCK_BYTES-1 byte of the block containing the s_last_i byte; else 0.
REQ-017 The length counter SHALL count accepted message bytes, pad excluded, modulo 2^LL_W.
REQ-018 core_ll_o SHALL be stable from the cycle after the s_last_i byte until IDLE; the counter SHALL clear on IDLE->FILL.
REQ-019 In RESULT, each core_h_v_i byte SHALL be forwarded registered, one cycle later, on res_data_o with res_v_o=1; there is no backpressure.
REQ-020 res_last_o SHALL be 1 with the cfg_nn-th result byte; later core_h_v_i bytes SHALL be ignored.
REQ-021 core_h_v_i outside RESULT SHALL be ignored.
REQ-022 s_valid_i with s_ready_o=0 SHALL NOT be consumed; data SHALL be held by the source.
REQ-023 busy_o SHALL be 1 in every state except IDLE.
REQ-024 Messages SHALL be at least 1 byte long; zero-length messages are unsupported.

Reset
REQ-025 On nreset=0, asynchronously: state IDLE; all counters 0; core_data_v_o, core_block_first_o, core_block_last_o, res_v_o, res_last_o, busy_o 0; core_data_o, core_data_idx_o, res_data_o, core_ll_o, core_nn_o, core_kk_o 0.
REQ-026 Reset mid-operation SHALL abandon the message with no further core or result output; the core SHALL share nreset.

Verification
REQ-027 3-byte message 0x61,0x62,0x63 (last on 0x63), cfg_nn=64 -> idx 0..2 carry data, idx 3..63 are 0x00, first=1 on all 64 bytes, last=1 on idx 3..63, ll=3; 64 res bytes, res_last on 64th, then IDLE.
REQ-028 64-byte message, last on byte 63 -> one block, no PAD, last=1 only on idx 63, ll=64, GAP->RESULT.
REQ-029 65-byte message -> block 0 first=1/last=0, s_ready_o=0 in GAP until core_ready_i=1 (min 2 cycles), block 1 byte idx 0 then 63 pad bytes, first=0, ll=65.
REQ-030 s_valid_i toggling every other cycle, core_ready_i forced 0 for 5 cycles mid-FILL -> no byte lost or duplicated, idx contiguous.
REQ-031 nreset pulse at FILL idx 20 -> all outputs 0 immediately, next message starts at idx 0 with first=1.
REQ-032 cfg_nn=32, core sends 64 digest bytes -> exactly 32 res_v_o pulses, res_last on 32nd, busy_o=0 afterward.

Source files
------------

// File: rtl/blake2_feeder.sv
// blake2_feeder: turns a byte stream into zero-padded BLAKE2 compression
// blocks for a byte-serial core, tracks the message length and key/digest
// configuration, and forwards the first cfg_nn digest bytes to the result port.
module blake2_feeder #(
  parameter int BLOCK_BYTES = 64,
  parameter int IDX_W       = 6,
  parameter int LL_W        = 128,
  parameter int NN_W        = 7
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             s_valid_i,
  input  logic [7:0]       s_data_i,
  input  logic             s_last_i,
  output logic             s_ready_o,
  input  logic [NN_W-1:0]  cfg_nn_i,
  input  logic [NN_W-1:0]  cfg_kk_i,
  input  logic             core_ready_i,
  output logic             core_data_v_o,
  output logic [IDX_W-1:0] core_data_idx_o,
  output logic [7:0]       core_data_o,
  output logic             core_block_first_o,
  output logic             core_block_last_o,
  output logic [LL_W-1:0]  core_ll_o,
  output logic [NN_W-1:0]  core_nn_o,
  output logic [NN_W-1:0]  core_kk_o,
  input  logic             core_h_v_i,
  input  logic [7:0]       core_h_i,
  output logic             res_v_o,
  output logic [7:0]       res_data_o,
  output logic             res_last_o,
  output logic             busy_o
);

  typedef enum logic [2:0] {IDLE, FILL, PAD, GAP, RESULT} state_t;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BLOCK_BYTES - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q;        // position of the next byte inside the block
  logic             first_q;      // current block is the first of the message
  logic             msg_end_q;    // the s_last_i byte has been accepted
  logic             gap_seen_q;   // previous cycle was already spent in GAP
  logic [NN_W-1:0]  res_cnt_q;    // digest bytes forwarded so far
  logic             accept;
  logic             h_take;

  // Source may only hand over bytes while a block is being filled.
  assign s_ready_o = ((state_q == IDLE) || (state_q == FILL)) && core_ready_i;
  assign accept    = s_valid_i && s_ready_o;
  assign busy_o    = (state_q != IDLE);

  // Next-state decode and digest-byte acceptance.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d = state_q;
    h_take  = 1'b0;
    unique case (state_q)
      IDLE, FILL: begin
        if (accept) begin
          if (idx_q == IDX_LAST)  state_d = GAP;
          else if (s_last_i)      state_d = PAD;
          else                    state_d = FILL;
        end
      end
      PAD: begin
        if (idx_q == IDX_LAST) state_d = GAP;
      end
      GAP: begin
        // Last block goes straight to the digest; otherwise give the core at
        // least two idle cycles and wait for it to be ready again.
        if (msg_end_q)                       state_d = RESULT;
        else if (gap_seen_q && core_ready_i) state_d = FILL;
      end
      RESULT: begin
        if (res_last_o) state_d = IDLE;
        else            h_take = core_h_v_i && (res_cnt_q != core_nn_o);
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and all registered core/result outputs.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q            <= IDLE;
      idx_q              <= '0;
      first_q            <= 1'b0;
      msg_end_q          <= 1'b0;
      gap_seen_q         <= 1'b0;
      res_cnt_q          <= '0;
      core_data_v_o      <= 1'b0;
      core_data_idx_o    <= '0;
      core_data_o        <= '0;
      core_block_first_o <= 1'b0;
      core_block_last_o  <= 1'b0;
      core_ll_o          <= '0;
      core_nn_o          <= '0;
      core_kk_o          <= '0;
      res_v_o            <= 1'b0;
      res_data_o         <= '0;
      res_last_o         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q            <= state_d;
      gap_seen_q         <= (state_q == GAP);
      core_data_v_o      <= 1'b0;
      core_block_first_o <= 1'b0;
      core_block_last_o  <= 1'b0;
      res_v_o            <= 1'b0;
      res_last_o         <= 1'b0;

      if (accept) begin
        core_data_v_o      <= 1'b1;
        core_data_o        <= s_data_i;
        core_data_idx_o    <= idx_q;
        core_block_first_o <= (state_q == IDLE) || first_q;
        core_block_last_o  <= s_last_i && (idx_q == IDX_LAST);
        idx_q              <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        core_ll_o          <= (state_q == IDLE) ? LL_W'(1) : core_ll_o + LL_W'(1);
        if (state_q == IDLE) begin
          core_nn_o <= cfg_nn_i;
          core_kk_o <= cfg_kk_i;
          first_q   <= 1'b1;
          msg_end_q <= 1'b0;
          res_cnt_q <= '0;
        end
        if (s_last_i)           msg_end_q <= 1'b1;
        if (idx_q == IDX_LAST)  first_q   <= 1'b0;
      end else if (state_q == PAD) begin
        core_data_v_o      <= 1'b1;
        core_data_o        <= 8'h00;
        core_data_idx_o    <= idx_q;
        core_block_first_o <= first_q;
        core_block_last_o  <= 1'b1;
        idx_q              <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        if (idx_q == IDX_LAST) first_q <= 1'b0;
      end

      if (h_take) begin
        res_v_o    <= 1'b1;
        res_data_o <= core_h_i;
        res_cnt_q  <= res_cnt_q + NN_W'(1);
        res_last_o <= ((res_cnt_q + NN_W'(1)) == core_nn_o);
      end
    end
  end

endmodule

// File: tb/tb_blake2_feeder.sv
// Self-checking bench for blake2_feeder: random and directed messages are
// compared beat by beat against a block/padding model built from the message.
module tb_blake2_feeder;

  localparam int BB    = 64;
  localparam int IDX_W = 6;
  localparam int LL_W  = 128;
  localparam int NN_W  = 7;

  logic             clk = 1'b0;
  logic             nreset = 1'b0;
  logic             s_valid_i = 1'b0;
  logic [7:0]       s_data_i = '0;
  logic             s_last_i = 1'b0;
  logic             s_ready_o;
  logic [NN_W-1:0]  cfg_nn_i = '0;
  logic [NN_W-1:0]  cfg_kk_i = '0;
  logic             core_ready_i = 1'b1;
  logic             core_data_v_o;
  logic [IDX_W-1:0] core_data_idx_o;
  logic [7:0]       core_data_o;
  logic             core_block_first_o;
  logic             core_block_last_o;
  logic [LL_W-1:0]  core_ll_o;
  logic [NN_W-1:0]  core_nn_o;
  logic [NN_W-1:0]  core_kk_o;
  logic             core_h_v_i = 1'b0;
  logic [7:0]       core_h_i = '0;
  logic             res_v_o;
  logic [7:0]       res_data_o;
  logic             res_last_o;
  logic             busy_o;

  blake2_feeder #(.BLOCK_BYTES(BB), .IDX_W(IDX_W), .LL_W(LL_W), .NN_W(NN_W)) dut (
    .clk(clk), .nreset(nreset),
    .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_last_i(s_last_i), .s_ready_o(s_ready_o),
    .cfg_nn_i(cfg_nn_i), .cfg_kk_i(cfg_kk_i), .core_ready_i(core_ready_i),
    .core_data_v_o(core_data_v_o), .core_data_idx_o(core_data_idx_o), .core_data_o(core_data_o),
    .core_block_first_o(core_block_first_o), .core_block_last_o(core_block_last_o),
    .core_ll_o(core_ll_o), .core_nn_o(core_nn_o), .core_kk_o(core_kk_o),
    .core_h_v_i(core_h_v_i), .core_h_i(core_h_i),
    .res_v_o(res_v_o), .res_data_o(res_data_o), .res_last_o(res_last_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]       data;
    logic [IDX_W-1:0] idx;
    logic             first;
    logic             last;
  } core_beat_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } res_beat_t;

  core_beat_t core_exp[$];
  res_beat_t  res_exp[$];
  logic [7:0] msg_q[$];
  core_beat_t ce;
  res_beat_t  re;
  int         n_checks = 0;
  int         n_pass   = 0;
  bit         rand_ready = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Monitor: every core beat and result beat must match the next expected one.
  initial forever begin
    @(negedge clk);
    if (nreset) begin
      if (core_data_v_o) begin
        if (core_exp.size() == 0) check("core_extra_beat", core_data_v_o, 1'b0);
        else begin
          ce = core_exp.pop_front();
          check("core_beat", {core_data_o, core_data_idx_o, core_block_first_o, core_block_last_o}, ce);
        end
      end
      if (res_v_o) begin
        if (res_exp.size() == 0) check("res_extra_beat", res_v_o, 1'b0);
        else begin
          re = res_exp.pop_front();
          check("res_beat", {res_data_o, res_last_o}, re);
        end
      end
    end
  end

  // Optional random core back-pressure.
  initial forever begin
    @(negedge clk);
    if (rand_ready) core_ready_i = ($urandom_range(3) != 0);
  end

  task automatic fill_rand(input int len);
    msg_q.delete();
    for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last, output int stalls);
    bit acc;
    acc = 1'b0;
    stalls = 0;
    s_valid_i = 1'b1;
    s_data_i  = d;
    s_last_i  = last;
    for (int t = 0; t < 500; t++) begin
      #1;
      if (s_ready_o) begin
        acc = 1'b1;
        break;
      end
      @(negedge clk);
      stalls++;
    end
    if (!acc) check("accept_timeout", s_ready_o, 1'b1);
    else @(negedge clk);
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
  endtask

  // Drives msg_q as one message, then plays the core's digest and checks results.
  task automatic run_msg(input int nn, input int kk, input int extra_h,
                         input bit toggle, input int abort_at);
    int len, total, stalls;
    len = msg_q.size();
    // Reference: data bytes fill blocks in order; the final partial block is
    // completed with zeros; first marks block 0, last marks the final block.
    for (int i = 0; i < len; i++)
      core_exp.push_back('{msg_q[i], IDX_W'(i % BB), 1'(i < BB),
                           1'((i == len - 1) && (i % BB == BB - 1))});
    if (len % BB != 0)
      for (int j = len % BB; j < BB; j++)
        core_exp.push_back('{8'h00, IDX_W'(j), 1'(len < BB), 1'b1});
    total = core_exp.size();
    cfg_nn_i = NN_W'(nn);
    cfg_kk_i = NN_W'(kk);

    for (int i = 0; i < len; i++) begin
      if (toggle) @(negedge clk);
      send_byte(msg_q[i], 1'(i == len - 1), stalls);
      if (!toggle && i > 0 && i % BB == 0) check("gap_min_stall", 1'(stalls >= 2), 1'b1);
      if (i == abort_at) begin
        #2;
        check("abort_pending", core_exp.size(), total - (abort_at + 1));
        nreset = 1'b0;
        #1;
        check("abort_ll_zero", core_ll_o, '0);
        check("abort_outs_zero", {core_data_v_o, core_data_idx_o, core_data_o, core_block_first_o,
                                  core_block_last_o, core_nn_o, core_kk_o, res_v_o, res_data_o,
                                  res_last_o, busy_o}, '0);
        core_exp.delete();
        @(negedge clk);
        nreset = 1'b1;
        return;
      end
    end

    for (int t = 0; t < 3000 && core_exp.size() != 0; t++) @(negedge clk);
    check("core_drain", core_exp.size(), 0);
    repeat (2) @(negedge clk);
    check("ll", core_ll_o, LL_W'(len));
    check("nn_kk", {core_nn_o, core_kk_o}, {NN_W'(nn), NN_W'(kk)});
    check("busy_result", busy_o, 1'b1);
    check("ready_result", s_ready_o, 1'b0);

    for (int k = 0; k < nn + extra_h; k++) begin
      core_h_v_i = 1'b1;
      core_h_i   = 8'($urandom);
      if (k < nn) res_exp.push_back('{core_h_i, 1'(k == nn - 1)});
      @(negedge clk);
      core_h_v_i = 1'b0;
      if ($urandom_range(2) == 0) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check("res_drain", res_exp.size(), 0);
    check("busy_idle", busy_o, 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_ll", core_ll_o, '0);
    check("reset_outs", {core_data_v_o, core_data_idx_o, core_data_o, core_block_first_o,
                         core_block_last_o, core_nn_o, core_kk_o, res_v_o, res_data_o,
                         res_last_o, busy_o}, '0);
    nreset = 1'b1;
    @(negedge clk);

    // "abc", full 64-byte digest.
    msg_q.delete();
    msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
    run_msg(64, 0, 0, 1'b0, -1);

    // Exactly one full block, no padding.
    fill_rand(64);
    run_msg(32, 5, 3, 1'b0, -1);

    // One byte past a block boundary.
    fill_rand(65);
    run_msg(16, 0, 2, 1'b0, -1);

    // Source toggling, core stalled for 5 cycles mid-fill, stray digest byte.
    fill_rand(100);
    fork
      run_msg(20, 3, 0, 1'b1, -1);
      begin
        repeat (12) @(negedge clk);
        core_ready_i = 1'b0;
        core_h_v_i   = 1'b1;
        core_h_i     = 8'h5a;
        @(negedge clk);
        core_h_v_i   = 1'b0;
        repeat (4) @(negedge clk);
        core_ready_i = 1'b1;
      end
    join

    // Reset in the middle of filling, then a 1-byte message from scratch.
    fill_rand(40);
    run_msg(8, 0, 0, 1'b0, 20);
    fill_rand(1);
    run_msg(8, 1, 0, 1'b0, -1);

    // Core produces more digest bytes than requested.
    fill_rand(10);
    run_msg(32, 0, 32, 1'b0, -1);

    // Random lengths, digest sizes and core back-pressure.
    rand_ready = 1'b1;
    for (int m = 0; m < 8; m++) begin
      fill_rand($urandom_range(1, 200));
      run_msg($urandom_range(1, 64), $urandom_range(0, 64), $urandom_range(0, 4),
              1'($urandom_range(1)), -1);
    end
    rand_ready   = 1'b0;
    core_ready_i = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
